// File: rtl/axi_read_arbiter_if.sv
// Bundled requester-side and master-side AXI4 read signals for the read arbiter.
// The arbiter uses the master modport; the environment (requesters plus slave) uses the slave modport.
interface axi_read_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_arvalid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr;
    logic [NUM_REQ*8-1:0]          req_arlen;
    logic [NUM_REQ-1:0]            req_arready;
    logic [NUM_REQ-1:0]            req_rvalid;
    logic [NUM_REQ-1:0]            req_rready;
    logic [DATA_WIDTH-1:0]         req_rdata;

    logic                          m_arvalid;
    logic [ADDR_WIDTH-1:0]         m_araddr;
    logic [7:0]                    m_arlen;
    logic                          m_arready;
    logic                          m_rvalid;
    logic                          m_rready;
    logic [DATA_WIDTH-1:0]         m_rdata;
    logic                          m_rlast;

    modport master (
        input  req_arvalid, req_araddr, req_arlen, req_rready,
        input  m_arready, m_rvalid, m_rdata, m_rlast,
        output req_arready, req_rvalid, req_rdata,
        output m_arvalid, m_araddr, m_arlen, m_rready
    );

    modport slave (
        output req_arvalid, req_araddr, req_arlen, req_rready,
        output m_arready, m_rvalid, m_rdata, m_rlast,
        input  req_arready, req_rvalid, req_rdata,
        input  m_arvalid, m_araddr, m_arlen, m_rready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel among NUM_REQ requesters,
// one burst outstanding, with beat tracking and a sticky RLAST-mismatch flag.
module axi_read_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_read_arbiter_if.master    bus,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic                  protocol_error
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e                  state_q;
    logic [IDW-1:0]          ptr_q;
    logic [IDW-1:0]          grant_q;
    logic [7:0]              cnt_q;
    logic [7:0]              len_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    perr_q;
    logic                    arvalid_q;
    logic                    busy_q;
    logic [IDW-1:0]          pick_d;
    logic                    beat_s;

    // First requesting index at or after ptr, wrapping from NUM_REQ-1 to 0.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && vld[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Round-robin candidate for the next grant.
    always_comb begin
        pick_d = rr_pick(bus.req_arvalid, ptr_q);
    end

    // Route address accept and read data between the granted requester and the master.
    always_comb begin
        bus.req_arready = '0;
        bus.req_rvalid  = '0;
        bus.m_rready    = 1'b0;
        bus.req_rdata   = '0;
        case (state_q)
            ST_ADDR: begin
                bus.req_arready[grant_q] = bus.m_arready;
            end
            ST_DATA: begin
                bus.req_rvalid[grant_q] = bus.m_rvalid;
                bus.m_rready            = bus.req_rready[grant_q];
                bus.req_rdata           = bus.m_rdata;
            end
            default: begin
                bus.req_rdata = '0;
            end
        endcase
    end

    assign beat_s = (state_q == ST_DATA) && bus.m_rvalid && bus.m_rready;

    // Arbitration, burst tracking and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            cnt_q     <= 8'd0;
            len_q     <= 8'd0;
            addr_q    <= '0;
            perr_q    <= 1'b0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req_arvalid) begin
                        grant_q   <= pick_d;
                        addr_q    <= bus.req_araddr[pick_d*ADDR_WIDTH +: ADDR_WIDTH];
                        len_q     <= bus.req_arlen[pick_d*8 +: 8];
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.m_arready) begin
                        cnt_q     <= len_q;
                        arvalid_q <= 1'b0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_s) begin
                        // A mismatched RLAST is flagged but the count still decides the end.
                        if (bus.m_rlast != (cnt_q == 8'd0)) begin
                            perr_q <= 1'b1;
                        end
                        if (cnt_q == 8'd0) begin
                            ptr_q   <= (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m_arvalid  = arvalid_q;
    assign bus.m_araddr   = addr_q;
    assign bus.m_arlen    = len_q;
    assign grant_id       = grant_q;
    assign busy           = busy_q;
    assign protocol_error = perr_q;
endmodule
